// File: rtl/ram_arbiter_pkg.sv
// Shared types for the cpu/host ram arbiter.
package ram_arbiter_pkg;

    // Arbiter ownership states; encodings are fixed so waveforms and debug tools agree.
    typedef enum logic [1:0] {
        StCpu   = 2'd0,  // cpu owns the ram, accesses pass straight through
        StHaddr = 2'd1,  // host address/command phase on the ram
        StHdata = 2'd2   // ram read data returns; host result registered on exit
    } arb_state_e;

    // Starvation counter width; a zero limit still needs a 1-bit counter.
    function automatic int unsigned starve_width(input int unsigned max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Shares the cpu's single-port ram with a host loader/debug port.
// The cpu owns the ram by default; the host is granted when the cpu is idle
// or after HOST_MAX_WAIT consecutive busy cycles, and the cpu is stalled
// for the two cycles the host transaction occupies.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned AW            = 8,
    parameter int unsigned DW            = 8,
    parameter int unsigned HOST_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rden,
    input  logic          cpu_wren,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    localparam int unsigned StarveW = starve_width(HOST_MAX_WAIT);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(HOST_MAX_WAIT);

    arb_state_e         state_q, state_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic               host_ack_q, host_ack_d;
    logic [DW-1:0]      host_rdata_q, host_rdata_d;

    logic cpu_busy;
    logic host_new;
    logic grant;
    logic rden_raw;
    logic wren_raw;

    assign cpu_busy = cpu_rden | cpu_wren;
    // A request still high during the ack cycle belongs to the finished transaction.
    assign host_new = host_req & ~host_ack_q;
    assign grant    = (state_q == StCpu) & host_new & (~cpu_busy | (starve_q == StarveMax));

    // Next-state, starvation counter and host result registers.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        unique case (state_q)
            StCpu: begin
                if (grant) begin
                    state_d  = StHaddr;
                    starve_d = '0;
                end else if (!host_req) begin
                    starve_d = '0;
                end else if (host_new && cpu_busy && starve_q != StarveMax) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            StHaddr: begin
                state_d = StHdata;
            end
            StHdata: begin
                state_d    = StCpu;
                host_ack_d = 1'b1;
                if (!host_we) begin
                    host_rdata_d = ram_q;
                end
            end
            default: begin
                state_d  = StCpu;
                starve_d = '0;
            end
        endcase
    end

    // Ram port mux; the cpu path is purely combinational.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_data  = cpu_wdata;
        rden_raw  = cpu_rden;
        wren_raw  = cpu_wren;
        cpu_stall = 1'b0;
        unique case (state_q)
            StCpu: begin
                cpu_stall = 1'b0;
            end
            StHaddr: begin
                ram_addr  = host_addr;
                ram_data  = host_wdata;
                rden_raw  = ~host_we;
                wren_raw  = host_we;
                cpu_stall = 1'b1;
            end
            StHdata: begin
                rden_raw  = 1'b0;
                wren_raw  = 1'b0;
                cpu_stall = 1'b1;
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    // Strobes are gated by reset so an in-flight access is killed immediately.
    assign ram_rden   = rden_raw & rst;
    assign ram_wren   = wren_raw & rst;
    assign cpu_rdata  = ram_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StCpu;
            starve_q     <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule
